// File: rtl/tlm_pkg.sv
// tlm_pkg: shared telemetry framer states, sync bytes and register map range
package tlm_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SYNC1,
    ST_LEN,
    ST_RD,
    ST_PAY,
    ST_CSUM
  } tlm_state_e;
  localparam logic [7:0] TLM_SYNC0      = 8'hA5;
  localparam logic [7:0] TLM_SYNC1      = 8'h5A;
  localparam logic [7:0] TLM_FIRST_ADDR = 8'd1;
  localparam logic [7:0] TLM_LAST_ADDR  = 8'd34;
  // payload length in bytes for an inclusive address range
  function automatic logic [7:0] tlm_len(input logic [7:0] first, input logic [7:0] last);
    return last - first + 8'd1;
  endfunction
endpackage

// File: rtl/tlm_period_timer.sv
// tlm_period_timer: free-running auto-trigger tick, silent when PERIOD is 0
module tlm_period_timer #(
  parameter int unsigned PERIOD = 0
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  logic [31:0] r_cnt;
  logic        w_last;
  assign w_last = (PERIOD != 0) && (r_cnt == PERIOD - 1);
  assign o_tick = w_last;
  // count 0..PERIOD-1 and wrap; stays parked at 0 when disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= (PERIOD == 0 || w_last) ? '0 : r_cnt + 32'd1;
  end
endmodule

// File: rtl/telemetry_framer.sv
// telemetry_framer: sweeps the sensor register file into a framed valid/ready byte stream
module telemetry_framer
  import tlm_pkg::*;
#(
  parameter logic [7:0]  FIRST_ADDR = TLM_FIRST_ADDR,
  parameter logic [7:0]  LAST_ADDR  = TLM_LAST_ADDR,
  parameter int unsigned PERIOD     = 0,
  parameter logic [7:0]  SYNC0      = TLM_SYNC0,
  parameter logic [7:0]  SYNC1      = TLM_SYNC1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  reg_addr,
  input  logic [7:0]  reg_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);
  localparam logic [7:0] LEN = tlm_len(FIRST_ADDR, LAST_ADDR);
  tlm_state_e r_state;
  logic [7:0] r_acc;
  logic       w_tick;
  logic       w_trig;
  logic       w_xfer;
  tlm_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );
  assign w_trig = start | w_tick;
  assign w_xfer = tx_valid & tx_ready;
  // frame sequencer: every output is registered so the byte and address hold while the sink stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      reg_addr   <= FIRST_ADDR;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      r_acc      <= '0;
    end else begin
      frame_done <= 1'b0;
      if (w_trig && r_state != ST_IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (r_state)
        ST_IDLE: if (w_trig) begin
          r_state  <= ST_SYNC0;
          busy     <= 1'b1;
          tx_valid <= 1'b1;
          tx_data  <= SYNC0;
        end
        ST_SYNC0: if (w_xfer) begin
          r_state <= ST_SYNC1;
          tx_data <= SYNC1;
        end
        ST_SYNC1: if (w_xfer) begin
          r_state <= ST_LEN;
          tx_data <= LEN;
        end
        ST_LEN: if (w_xfer) begin
          r_state  <= ST_RD;
          tx_valid <= 1'b0;
          r_acc    <= LEN;
          reg_addr <= FIRST_ADDR;
        end
        ST_RD: begin
          r_state  <= ST_PAY;
          tx_valid <= 1'b1;
          tx_data  <= reg_data;
          r_acc    <= r_acc + reg_data;
        end
        ST_PAY: if (w_xfer) begin
          if (reg_addr == LAST_ADDR) begin
            r_state <= ST_CSUM;
            tx_data <= r_acc;
          end else begin
            r_state  <= ST_RD;
            tx_valid <= 1'b0;
            reg_addr <= reg_addr + 8'd1;
          end
        end
        ST_CSUM: if (w_xfer) begin
          r_state    <= ST_IDLE;
          tx_valid   <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
- Downstream consumer of the sensor register file.
- Sweeps the register file's byte address range, reading one byte per address through its combinational addr->data port.
- Wraps the bytes into a framed telemetry packet: sync, length, payload, checksum.
- Streams the packet one byte at a time over a valid/ready interface to the radio/UART transmitter.

Parameters:
- FIRST_ADDR, 8'd1: first register address read into the payload.
- LAST_ADDR, 8'd34: last register address read, inclusive. Must be >= FIRST_ADDR.
- PERIOD, 0: auto-trigger interval in clk cycles. 0 disables auto-trigger (start port only).
- SYNC0, 8'hA5: first sync byte.
- SYNC1, 8'h5A: second sync byte.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send a frame.
- reg_addr  out  8  address to the sensor register file.
- reg_data  in  8  byte returned by the sensor register file for reg_addr.
- tx_data  out  8  frame byte to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the checksum byte transfers.
- frame_cnt  out  16  completed frames; wraps modulo 2^16.
- drop_cnt  out  8  triggers ignored because busy; saturates at 255.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state IDLE;
  - tx_valid=0, tx_data=0, reg_addr=FIRST_ADDR;
  - busy=0, frame_done=0, frame_cnt=0, drop_cnt=0;
  - checksum accumulator=0, period counter=0.
- Reset mid-frame aborts the frame immediately; there is no partial resume.
- Trigger = start OR period tick.
  - The period tick fires when the free-running counter reaches PERIOD-1, then the counter returns to 0.
- Trigger in IDLE: go to SYNC0 next cycle; busy goes high.
- Trigger when not in IDLE: drop_cnt += 1 (saturating); the frame in progress is unaffected.
- Simultaneous start and tick count as one trigger.
- Frame layout: SYNC0, SYNC1, LEN, payload bytes reg[FIRST_ADDR..LAST_ADDR], CSUM.
  - LEN = LAST_ADDR-FIRST_ADDR+1 (default 8'h22).
  - CSUM = (LEN + sum of payload bytes) mod 256. Sync bytes are excluded.
- States: IDLE, SYNC0, SYNC1, LEN, RD, PAY, CSUM.
  - SYNC0/SYNC1/LEN/CSUM: present the byte with tx_valid=1; advance on tx_valid&&tx_ready.
    - LEN transfer loads the accumulator with LEN, sets reg_addr=FIRST_ADDR, and goes to RD.
  - RD: tx_valid=0; reg_addr stable for one full cycle. At the cycle's end, capture reg_data into tx_data, add it to the accumulator, go to PAY.
  - PAY: tx_valid=1. On transfer:
    - if reg_addr==LAST_ADDR, go to CSUM;
    - else reg_addr += 1 and go to RD.
  - CSUM transfer: go to IDLE; frame_done=1 for one cycle; frame_cnt += 1; busy drops in the same cycle.
- Handshake rules:
  - While tx_valid && !tx_ready, tx_data and reg_addr hold; tx_valid never deasserts without a transfer, except on reset.
  - tx_ready is ignored when tx_valid=0.
- Latency with tx_ready tied high, default range:
  - first tx_valid one cycle after the trigger;
  - 3 header cycles + 34×2 payload cycles + 1 CSUM cycle = 72 cycles to the last transfer;
  - frame_done on cycle 73.
- Each payload byte is sampled once in RD and held. Multi-byte sensor fields may tear across bytes; no snapshot is required of this block.
- Arithmetic: the accumulator is 8 bits, wrapping. reg_addr never exceeds LAST_ADDR.

Decomposition:
- Shared package tlm_pkg holds:
  - state enum (IDLE..CSUM);
  - SYNC0/SYNC1 defaults;
  - register map range constants: TLM_FIRST_ADDR=1, TLM_LAST_ADDR=34.
  - The sensor register file and ground-side decoder use the same range constants.
- One natural sub-module: tlm_period_timer. It takes PERIOD and outputs a one-cycle tick; when PERIOD==0 the tick is tied low.
- The FSM, checksum, and counters stay in telemetry_framer.

Test Plan:
- Register model returns reg_data=reg_addr, tx_ready=1, pulse start. Expected:
  - 38 bytes: A5 5A 22 01 02 … 22 75;
  - frame_done on cycle 73;
  - frame_cnt=1.
- Register model returns 8'h00. Expected: payload all 00, CSUM=8'h22.
- Drop tx_ready for 5 cycles while the 10th payload byte is valid. Expected: tx_data=8'h0A and reg_addr=10 held stable, no byte lost or duplicated, CSUM still 75.
- Pulse start again mid-frame, 300 times across frames. Expected: current frame completes unchanged; drop_cnt saturates at 255 without wrapping.
- Set PERIOD=100, tx_ready=1, no start. Expected: a frame begins every 100 cycles, frame_cnt increments each, drop_cnt=0. Then set PERIOD=50. Expected: drop_cnt increments once per overlapping tick.
- Assert rst low during the 20th payload byte. Expected: tx_valid=0 and busy=0 asynchronously, counters 0. After release and start, a full, correct frame is sent from SYNC0.
